// File: rtl/dport_mmio_bridge_pkg.sv
// Shared definitions for the data-port MMIO bridge: MMIO register offsets,
// bridge FSM states, address regions and the latched local response.
package dport_mmio_bridge_pkg;

    localparam int unsigned TagW = 11;

    // MMIO register offsets within the 256-byte window
    localparam logic [7:0] OffTx     = 8'h00;
    localparam logic [7:0] OffTohost = 8'h04;
    localparam logic [7:0] OffCycLo  = 8'h08;
    localparam logic [7:0] OffCycHi  = 8'h0C;

    typedef enum logic [1:0] {
        StIdle,
        StLocalResp,
        StTxWait
    } state_e;

    typedef enum logic [1:0] {
        RegionRam,
        RegionMmio,
        RegionUnmapped
    } region_e;

    typedef struct packed {
        logic [TagW-1:0] tag;
        logic [31:0]     data;
        logic            error;
    } resp_t;

    // RAM occupies [0, ram_bytes); MMIO is the 256-byte page at mmio_base
    function automatic region_e decode_region(input logic [31:0] addr,
                                              input logic [31:0] ram_bytes,
                                              input logic [31:0] mmio_base);
        if (addr < ram_bytes) begin
            return RegionRam;
        end
        if (addr[31:8] == mmio_base[31:8]) begin
            return RegionMmio;
        end
        return RegionUnmapped;
    endfunction

endpackage

// File: rtl/dport_mmio_regs.sv
// MMIO register file: free-running cycle counter with high-word snapshot,
// sticky tohost result and the console TX byte.
module dport_mmio_regs
    import dport_mmio_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,       // MMIO request present this cycle
    input  logic        acc,       // MMIO request accepted this cycle
    input  logic [7:0]  offset,
    input  logic        ren,
    input  logic [3:0]  wen,
    input  logic [31:0] wdata,
    input  logic        tx_hold,   // bridge is holding a byte until tx_ready
    output logic [31:0] rdata,
    output logic        tx_write,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        sim_done,
    output logic [30:0] sim_code
);

    logic [63:0] cyc_q;
    logic [31:0] snap_q;
    logic        done_q;
    logic [30:0] code_q;
    logic [7:0]  tx_data_q;
    logic        tx_fire;

    // Console write needs byte lane 0; other lanes alone are ignored
    assign tx_write = sel && (offset == OffTx) && core_lane0(wen);
    assign tx_fire  = acc && tx_write;

    function automatic logic core_lane0(input logic [3:0] be);
        return be[0];
    endfunction

    // Register state: counter always runs, side effects only on accepted requests
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q     <= 64'd0;
            snap_q    <= 32'd0;
            done_q    <= 1'b0;
            code_q    <= 31'd0;
            tx_data_q <= 8'd0;
        end else begin
            cyc_q <= cyc_q + 64'd1;
            // Low-word read freezes the high word so a lo/hi pair is coherent
            if (acc && ren && (offset == OffCycLo)) begin
                snap_q <= cyc_q[63:32];
            end
            if (acc && (|wen) && (offset == OffTohost)) begin
                done_q <= 1'b1;
                code_q <= wdata[31:1];
            end
            if (tx_fire) begin
                tx_data_q <= wdata[7:0];
            end
        end
    end

    // Read mux; writes and unknown offsets return zero
    always_comb begin
        rdata = 32'd0;
        if (ren) begin
            case (offset)
                OffTohost: rdata = {code_q, done_q};
                OffCycLo:  rdata = cyc_q[31:0];
                OffCycHi:  rdata = snap_q;
                default:   rdata = 32'd0;
            endcase
        end
    end

    // The byte is offered in the accept cycle and held while the bridge waits
    always_comb begin
        tx_valid = tx_fire || tx_hold;
        tx_data  = tx_fire ? wdata[7:0] : tx_data_q;
    end

    assign sim_done = done_q;
    assign sim_code = code_q;

endmodule

// File: rtl/dport_mmio_bridge.sv
// Data-port bridge: RAM traffic passes straight through with an
// outstanding-request limit; MMIO and unmapped accesses are answered locally,
// only when no RAM request is in flight so responses stay in order.
module dport_mmio_bridge
    import dport_mmio_bridge_pkg::*;
#(
    parameter int unsigned RAM_BYTES = 8192,
    parameter logic [31:0] MMIO_BASE = 32'h8000_0000,
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     core__d_addr,
    input  logic [31:0]     core__d_wdata,
    input  logic            core__d_ren,
    input  logic [3:0]      core__d_wen,
    input  logic [TagW-1:0] core__d_req_tag,
    output logic            d__core_accept,
    output logic            d__core_val,
    output logic            d__core_error,
    output logic [31:0]     d__core_rdata,
    output logic [TagW-1:0] d__core_resp_tag,
    output logic [31:0]     br__m_addr,
    output logic [31:0]     br__m_wdata,
    output logic            br__m_ren,
    output logic [3:0]      br__m_wen,
    output logic [TagW-1:0] br__m_req_tag,
    input  logic            m__br_accept,
    input  logic            m__br_val,
    input  logic            m__br_error,
    input  logic [31:0]     m__br_rdata,
    input  logic [TagW-1:0] m__br_resp_tag,
    output logic            tx_valid,
    output logic [7:0]      tx_data,
    input  logic            tx_ready,
    output logic            sim_done,
    output logic [30:0]     sim_code
);

    localparam int unsigned     CntW   = $clog2(MAX_OUTST + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_OUTST);

    state_e          state_q, state_d;
    resp_t           resp_q, resp_d;
    logic [CntW-1:0] outst_q;

    region_e     region;
    logic        req;
    logic        is_ram;
    logic        ram_ok;
    logic        local_ok;
    logic        ram_fwd;
    logic        ram_acc;
    logic        local_acc;
    logic        mmio_sel;
    logic        mmio_acc;
    logic        tx_hold;
    logic        tx_write;
    logic [31:0] reg_rdata;

    // Request decode and acceptance
    always_comb begin
        req       = core__d_ren || (|core__d_wen);
        region    = decode_region(core__d_addr, 32'(RAM_BYTES), MMIO_BASE);
        is_ram    = (region == RegionRam);
        ram_ok    = (state_q == StIdle) && (outst_q != MaxCnt);
        local_ok  = (state_q == StIdle) && (outst_q == '0);
        ram_fwd   = req && is_ram && ram_ok;
        ram_acc   = ram_fwd && m__br_accept;
        local_acc = req && !is_ram && local_ok;
        mmio_sel  = req && (region == RegionMmio);
        mmio_acc  = local_acc && (region == RegionMmio);
        tx_hold   = (state_q == StTxWait);
        d__core_accept = ram_acc || local_acc;
    end

    // RAM-side request: address/data/tag pass through, strobes only when allowed
    always_comb begin
        br__m_addr    = core__d_addr;
        br__m_wdata   = core__d_wdata;
        br__m_req_tag = core__d_req_tag;
        br__m_ren     = ram_fwd && core__d_ren;
        br__m_wen     = ram_fwd ? core__d_wen : 4'b0000;
    end

    // Outstanding RAM requests; a stray response at zero (after reset) is ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            outst_q <= '0;
        end else if (ram_acc && !m__br_val) begin
            outst_q <= outst_q + CntW'(1);
        end else if (!ram_acc && m__br_val && (outst_q != '0)) begin
            outst_q <= outst_q - CntW'(1);
        end
    end

    // FSM state and latched local response
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            resp_q  <= resp_d;
        end
    end

    // FSM next state: capture the local answer on accept, then respond once
    always_comb begin
        state_d = state_q;
        resp_d  = resp_q;
        case (state_q)
            StIdle: begin
                if (local_acc) begin
                    resp_d.tag   = core__d_req_tag;
                    resp_d.error = (region == RegionUnmapped);
                    resp_d.data  = (region == RegionMmio) ? reg_rdata : 32'd0;
                    state_d      = (tx_write && !tx_ready) ? StTxWait : StLocalResp;
                end
            end
            StTxWait: begin
                if (tx_ready) begin
                    state_d = StLocalResp;
                end
            end
            StLocalResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Response mux; local and RAM responses cannot overlap
    always_comb begin
        if (state_q == StLocalResp) begin
            d__core_val      = 1'b1;
            d__core_error    = resp_q.error;
            d__core_rdata    = resp_q.data;
            d__core_resp_tag = resp_q.tag;
        end else begin
            d__core_val      = m__br_val;
            d__core_error    = m__br_error;
            d__core_rdata    = m__br_rdata;
            d__core_resp_tag = m__br_resp_tag;
        end
    end

    dport_mmio_regs u_regs (
        .clk      (clk),
        .rst      (rst),
        .sel      (mmio_sel),
        .acc      (mmio_acc),
        .offset   (core__d_addr[7:0]),
        .ren      (core__d_ren),
        .wen      (core__d_wen),
        .wdata    (core__d_wdata),
        .tx_hold  (tx_hold),
        .rdata    (reg_rdata),
        .tx_write (tx_write),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .sim_done (sim_done),
        .sim_code (sim_code)
    );

endmodule

// File: doc/dport_mmio_bridge.md
DPORT_MMIO_BRIDGE -- requirements
Module: dport_mmio_bridge

Interface
REQ-001 SHALL have parameter RAM_BYTES, default 8192, size of RAM window starting at 0x0000_0000.
REQ-002 SHALL have parameter MMIO_BASE, default 32'h8000_0000, base of 256-byte MMIO window.
REQ-003 SHALL have parameter MAX_OUTST, default 4, maximum RAM requests in flight.
REQ-004 SHALL use a single clock; reset is synchronous and active-high.
REQ-005 clk  in  1  clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 core__d_addr/core__d_wdata  in  32/32  core request address, write data.
REQ-008 core__d_ren  in  1 / core__d_wen  in  4 / core__d_req_tag  in  11  read strobe, byte write enables, request tag.
REQ-009 d__core_accept  out  1  request taken this cycle.
REQ-010 d__core_val/d__core_error  out  1/1  response valid, response error.
REQ-011 d__core_rdata/d__core_resp_tag  out  32/11  response data, echoed tag.
REQ-012 br__m_addr/br__m_wdata/br__m_ren/br__m_wen/br__m_req_tag  out  32/32/1/4/11  RAM-side request (same meaning as core side).
REQ-013 m__br_accept/m__br_val/m__br_error/m__br_rdata/m__br_resp_tag  in  1/1/1/32/11  RAM-side accept and response.
REQ-014 tx_valid/tx_data  out  1/8, tx_ready  in  1  console byte stream.
REQ-015 sim_done/sim_code  out  1/31  tohost result.

Function
REQ-016 Request exists when core__d_ren=1 or core__d_wen!=0; decode: RAM if addr<RAM_BYTES, MMIO if addr[31:8]==MMIO_BASE[31:8], else UNMAPPED.
REQ-017 RAM requests SHALL pass combinationally to br__m_*; d__core_accept=m__br_accept; RAM responses SHALL pass combinationally to d__core_*.
REQ-018 br__m_ren/br__m_wen SHALL be zero for non-RAM requests.
REQ-019 SHALL keep outstanding counter: +1 on accepted RAM request, -1 on m__br_val, both same cycle = unchanged.
REQ-020 RAM requests SHALL not be accepted (br__m_* strobes gated to 0) when counter==MAX_OUTST or state!=IDLE.
REQ-021 MMIO/UNMAPPED requests SHALL not be accepted while counter!=0 (preserves in-order responses).
REQ-022 States: IDLE, LOCAL_RESP, TX_WAIT.
REQ-023 IDLE: accepted MMIO/UNMAPPED request latches tag, data, error; goes LOCAL_RESP, except TX write with tx_ready=0 goes TX_WAIT.
REQ-024 LOCAL_RESP: d__core_val=1 for exactly one cycle with latched tag/data/error; returns to IDLE; accept=0.
REQ-025 TX_WAIT: tx_valid=1 held with latched byte until tx_ready=1, then LOCAL_RESP; accept=0.
REQ-026 MMIO offset 0x00 write (wen[0]=1): emit wdata[7:0] on tx_data with tx_valid for one cycle (if tx_ready) else via TX_WAIT; read returns 0.
REQ-027 Offset 0x04 write: sim_done<=1, sim_code<=wdata[31:1]; sticky until reset; read returns {sim_code,sim_done}.
REQ-028 Offsets 0x08/0x0C read: low/high word of 64-bit free-running cycle counter; high word read SHALL return value snapshotted at last low-word read.
REQ-029 Other MMIO offsets: reads return 0, writes ignored, error=0.
REQ-030 UNMAPPED: response with d__core_error=1, rdata=0, no side effect.
REQ-031 d__core_val from RAM and LOCAL_RESP SHALL never coincide (guaranteed by REQ-021).

Reset
REQ-032 On rst: state=IDLE, counter=0, cycle counter=0, snapshot=0, sim_done=0, sim_code=0, tx_valid=0, tx_data=0, latched response=0.
REQ-033 Reset mid-operation SHALL drop local responses and TX_WAIT; RAM responses after reset SHALL be forwarded without underflowing counter (saturate at 0).

Structure
REQ-034 Shared package SHALL hold MMIO offset constants (TX=0x00, TOHOST=0x04, CYC_LO=0x08, CYC_HI=0x0C) and state enum.
REQ-035 One sub-module natural: dport_mmio_regs (cycle counter, snapshot, tohost, TX registers).

Verification
REQ-036 RAM read addr 0x100 tag 5, RAM responds 0xDEADBEEF -> d__core_val=1, rdata 0xDEADBEEF, resp_tag 5.
REQ-037 Four RAM reads unanswered -> fifth RAM read accept=0 until one m__br_val.
REQ-038 Write 0x41 to 0x8000_0000 with tx_ready=0 for 3 cycles -> tx_valid held 3+ cycles, tx_data 0x41, core response one cycle after tx_ready.
REQ-039 Write 0x7 to 0x8000_0004 -> sim_done=1, sim_code=3; read returns 0x7.
REQ-040 Read 0x4000_0000 tag 9 -> d__core_error=1, rdata 0, resp_tag 9.
REQ-041 MMIO read issued with 2 RAM reads outstanding -> accept=0 until both RAM responses return, then MMIO response follows in order.
